// File: rtl/axi_write_slave_mc_if.sv
// AXI4 write-channel bundle (AW, W, B) shared by the multi-channel write slave and its masters.
interface axi_write_slave_mc_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic                    s_axi_awready;
  logic                    s_axi_awvalid;
  logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
  logic [ID_WIDTH-1:0]     s_axi_awid;
  logic [7:0]              s_axi_awlen;
  logic [2:0]              s_axi_awsize;
  logic [1:0]              s_axi_awburst;

  logic                    s_axi_wready;
  logic                    s_axi_wvalid;
  logic [DATA_WIDTH-1:0]   s_axi_wdata;
  logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
  logic                    s_axi_wlast;

  logic                    s_axi_bready;
  logic                    s_axi_bvalid;
  logic [ID_WIDTH-1:0]     s_axi_bid;
  logic [1:0]              s_axi_bresp;

  modport master (
    input  s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bid, s_axi_bresp,
    output s_axi_awvalid, s_axi_awaddr, s_axi_awid, s_axi_awlen, s_axi_awsize, s_axi_awburst,
    output s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_bready
  );

  modport slave (
    output s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bid, s_axi_bresp,
    input  s_axi_awvalid, s_axi_awaddr, s_axi_awid, s_axi_awlen, s_axi_awsize, s_axi_awburst,
    input  s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_bready
  );
endinterface

// File: rtl/axi_write_slave_mc.sv
// AXI4 write slave fanning NUM_CH consecutive word addresses out to NUM_CH ready/valid streams.
// Optional burst-length checking is enabled with `define AXI_WRITE_SLAVE_MC_LEN_CHECK_EN.
module axi_write_slave_mc #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ID_WIDTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    NUM_CH     = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  axi_write_slave_mc_if.slave            s_axi,
  output logic [NUM_CH-1:0]              out_valid,
  input  logic [NUM_CH-1:0]              out_ready,
  output logic [NUM_CH*DATA_WIDTH-1:0]   out_data,
  output logic [NUM_CH*DATA_WIDTH/8-1:0] out_strb
);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE_WORD = BASE_ADDR >> ADDR_LSB;
  localparam logic [ADDR_WIDTH-1:0] NUM_CH_A  = ADDR_WIDTH'(NUM_CH);
  localparam logic [CH_W-1:0]       LAST_CH   = CH_W'(NUM_CH - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {IDLE, DATA, DRAIN, RESP} state_t;

  state_t              state_reg, state_next;
  logic [CH_W-1:0]     ch_reg, ch_next;
  logic                fixed_reg, fixed_next;
  logic [1:0]          resp_reg, resp_next;
  logic [ID_WIDTH-1:0] bid_reg, bid_next;
  logic [7:0]          len_reg, len_next;
`ifdef AXI_WRITE_SLAVE_MC_LEN_CHECK_EN
  logic [8:0]          cnt_reg, cnt_next;
`else
  logic                unused_len;
  assign unused_len = ^len_reg;
`endif

  logic awready_c, wready_c, bvalid_c, fwd_c, w_hs;
  logic [ADDR_WIDTH-1:0] word_addr, ch_off;
  logic addr_ok, size_ok, burst_ok;
  logic [1:0] aw_resp;
  logic [DATA_WIDTH-1:0] wdata_masked;

  // Address decode works on word offsets so the range test never wraps past the base.
  assign word_addr = s_axi.s_axi_awaddr >> ADDR_LSB;
  assign ch_off    = word_addr - BASE_WORD;
  assign addr_ok   = (word_addr >= BASE_WORD) && (ch_off < NUM_CH_A);
  assign size_ok   = s_axi.s_axi_awsize <= 3'(ADDR_LSB);
  assign burst_ok  = (s_axi.s_axi_awburst == BURST_FIXED) || (s_axi.s_axi_awburst == BURST_INCR);
  assign aw_resp   = !addr_ok ? RESP_DECERR :
                     (!size_ok || !burst_ok) ? RESP_SLVERR : RESP_OKAY;

  assign w_hs = s_axi.s_axi_wvalid && wready_c;

  always_comb begin
    state_next = state_reg;
    ch_next    = ch_reg;
    fixed_next = fixed_reg;
    resp_next  = resp_reg;
    bid_next   = bid_reg;
    len_next   = len_reg;
`ifdef AXI_WRITE_SLAVE_MC_LEN_CHECK_EN
    cnt_next   = cnt_reg;
`endif
    awready_c  = 1'b0;
    wready_c   = 1'b0;
    bvalid_c   = 1'b0;
    fwd_c      = 1'b0;
    case (state_reg)
      IDLE: begin
        awready_c = 1'b1;
        if (s_axi.s_axi_awvalid) begin
          bid_next   = s_axi.s_axi_awid;
          len_next   = s_axi.s_axi_awlen;
          fixed_next = (s_axi.s_axi_awburst == BURST_FIXED);
          ch_next    = ch_off[CH_W-1:0];
          resp_next  = aw_resp;
`ifdef AXI_WRITE_SLAVE_MC_LEN_CHECK_EN
          cnt_next   = '0;
`endif
          state_next = (aw_resp == RESP_OKAY) ? DATA : DRAIN;
        end
      end
      DATA: begin
        fwd_c    = 1'b1;
        wready_c = out_ready[ch_reg];
        if (w_hs) begin
          if (s_axi.s_axi_wlast) begin
            state_next = RESP;
          end else if (!fixed_reg && ch_reg == LAST_CH) begin
            // Next INCR beat would land beyond the last channel.
            state_next = DRAIN;
            resp_next  = RESP_SLVERR;
          end else if (!fixed_reg) begin
            ch_next = ch_reg + CH_W'(1);
          end
        end
      end
      DRAIN: begin
        wready_c = 1'b1;
        if (w_hs && s_axi.s_axi_wlast) state_next = RESP;
      end
      RESP: begin
        bvalid_c = 1'b1;
        if (s_axi.s_axi_bready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
`ifdef AXI_WRITE_SLAVE_MC_LEN_CHECK_EN
    // wlast must coincide exactly with beat awlen+1; an overrun without wlast is drained.
    if (w_hs && (state_reg == DATA || state_reg == DRAIN)) begin
      cnt_next = cnt_reg + 9'd1;
      if (s_axi.s_axi_wlast != (cnt_reg == {1'b0, len_reg})) begin
        if (resp_reg != RESP_DECERR) resp_next = RESP_SLVERR;
        if (!s_axi.s_axi_wlast) state_next = DRAIN;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      ch_reg    <= '0;
      fixed_reg <= 1'b0;
      resp_reg  <= RESP_OKAY;
      bid_reg   <= '0;
      len_reg   <= '0;
`ifdef AXI_WRITE_SLAVE_MC_LEN_CHECK_EN
      cnt_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      ch_reg    <= ch_next;
      fixed_reg <= fixed_next;
      resp_reg  <= resp_next;
      bid_reg   <= bid_next;
      len_reg   <= len_next;
`ifdef AXI_WRITE_SLAVE_MC_LEN_CHECK_EN
      cnt_reg   <= cnt_next;
`endif
    end
  end

  // Handshake outputs are forced low while reset is held, even before the state clears.
  assign s_axi.s_axi_awready = reset && awready_c;
  assign s_axi.s_axi_wready  = reset && wready_c;
  assign s_axi.s_axi_bvalid  = reset && bvalid_c;
  assign s_axi.s_axi_bid     = bid_reg;
  assign s_axi.s_axi_bresp   = resp_reg;

  genvar gi;
  generate
    for (gi = 0; gi < STRB_W; gi++) begin : g_mask
      assign wdata_masked[gi*8 +: 8] = s_axi.s_axi_wstrb[gi] ? s_axi.s_axi_wdata[gi*8 +: 8] : 8'h00;
    end
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic sel;
      assign sel = reset && fwd_c && (ch_reg == CH_W'(gi));
      assign out_valid[gi] = sel && s_axi.s_axi_wvalid;
      assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] = sel ? wdata_masked : '0;
      assign out_strb[gi*STRB_W +: STRB_W]         = sel ? s_axi.s_axi_wstrb : '0;
    end
  endgenerate
endmodule
